// File: rtl/matmul_loader.sv
// Job loader for the matrix multiplier: validates a descriptor, buffers A then B from
// a single element stream, and replays both operands in lockstep after a start pulse.
module matmul_loader #(
  parameter int BUF_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [63:0] cfg_dims_a,
  input  logic [63:0] cfg_dims_b,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        mm_start,
  output logic [63:0] mm_dims_a,
  output logic [63:0] mm_dims_b,
  output logic [31:0] mm_in_a,
  output logic [31:0] mm_in_b,
  input  logic [31:0] mm_state,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int          AW       = (BUF_SIZE > 2) ? $clog2(BUF_SIZE) : 1;
  localparam logic [63:0] BUF_LIM  = 64'(BUF_SIZE);
  localparam logic [31:0] MM_IDLE  = 32'd0;
  localparam logic [31:0] MM_ERROR = 32'd4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_A    = 3'd1,
    S_LOAD_B    = 3'd2,
    S_START     = 3'd3,
    S_STREAM    = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_ERR       = 3'd6
  } state_t;

  state_t      state_r;
  logic [31:0] idx_r;
  logic [31:0] cnt_a_r;
  logic [31:0] cnt_b_r;
  logic [31:0] len_r;
  logic        cfg_ready_r;
  logic        s_ready_r;
  logic        mm_start_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic [63:0] mm_dims_a_r;
  logic [63:0] mm_dims_b_r;
  logic [31:0] mm_in_a_r;
  logic [31:0] mm_in_b_r;

  logic [31:0] buf_a [BUF_SIZE];
  logic [31:0] buf_b [BUF_SIZE];

  logic [63:0] prod_a_s;
  logic [63:0] prod_b_s;
  logic [31:0] len_s;
  logic        desc_ok_s;
  logic [31:0] nxt_a_s;
  logic [31:0] nxt_b_s;

  // Descriptor check; products are formed at 64 bits so huge dims cannot alias into range
  always_comb begin
    prod_a_s  = {32'd0, cfg_dims_a[63:32]} * {32'd0, cfg_dims_a[31:0]};
    prod_b_s  = {32'd0, cfg_dims_b[63:32]} * {32'd0, cfg_dims_b[31:0]};
    len_s     = (prod_a_s[31:0] > prod_b_s[31:0]) ? prod_a_s[31:0] : prod_b_s[31:0];
    desc_ok_s = (cfg_dims_a[63:32] != 32'd0) && (cfg_dims_a[31:0] != 32'd0) &&
                (cfg_dims_b[63:32] != 32'd0) && (cfg_dims_b[31:0] != 32'd0) &&
                (cfg_dims_a[31:0] == cfg_dims_b[63:32]) &&
                (prod_a_s < BUF_LIM) && (prod_b_s < BUF_LIM);
  end

  // Operand read for the next stream beat; the shorter operand pads with zeros
  always_comb begin
    nxt_a_s = (idx_r < cnt_a_r) ? buf_a[idx_r[AW-1:0]] : 32'd0;
    nxt_b_s = (idx_r < cnt_b_r) ? buf_b[idx_r[AW-1:0]] : 32'd0;
  end

  // Operand buffers, deliberately not reset
  always_ff @(posedge clk) begin
    if (!rst && s_valid && (state_r == S_LOAD_A)) buf_a[idx_r[AW-1:0]] <= s_data;
    if (!rst && s_valid && (state_r == S_LOAD_B)) buf_b[idx_r[AW-1:0]] <= s_data;
  end

  // Job sequencer with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      idx_r       <= 32'd0;
      cnt_a_r     <= 32'd0;
      cnt_b_r     <= 32'd0;
      len_r       <= 32'd0;
      cfg_ready_r <= 1'b1;
      s_ready_r   <= 1'b0;
      mm_start_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      mm_dims_a_r <= 64'd0;
      mm_dims_b_r <= 64'd0;
      mm_in_a_r   <= 32'd0;
      mm_in_b_r   <= 32'd0;
    end else begin
      mm_start_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (cfg_valid) begin
            cfg_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (desc_ok_s) begin
              mm_dims_a_r <= cfg_dims_a;
              mm_dims_b_r <= cfg_dims_b;
              cnt_a_r     <= prod_a_s[31:0];
              cnt_b_r     <= prod_b_s[31:0];
              len_r       <= len_s;
              idx_r       <= 32'd0;
              s_ready_r   <= 1'b1;
              state_r     <= S_LOAD_A;
            end else begin
              err_r   <= 1'b1;
              state_r <= S_ERR;
            end
          end
        end
        S_LOAD_A: begin
          if (s_valid) begin
            if (idx_r == cnt_a_r - 32'd1) begin
              idx_r   <= 32'd0;
              state_r <= S_LOAD_B;
            end else begin
              idx_r <= idx_r + 32'd1;
            end
          end
        end
        S_LOAD_B: begin
          if (s_valid) begin
            if (idx_r == cnt_b_r - 32'd1) begin
              idx_r      <= 32'd0;
              s_ready_r  <= 1'b0;
              mm_start_r <= 1'b1;
              state_r    <= S_START;
            end else begin
              idx_r <= idx_r + 32'd1;
            end
          end
        end
        S_START: begin
          mm_in_a_r <= nxt_a_s;
          mm_in_b_r <= nxt_b_s;
          idx_r     <= idx_r + 32'd1;
          state_r   <= S_STREAM;
        end
        S_STREAM: begin
          if (mm_state == MM_ERROR) begin
            err_r       <= 1'b1;
            mm_in_a_r   <= 32'd0;
            mm_in_b_r   <= 32'd0;
            idx_r       <= 32'd0;
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end else if (idx_r == len_r) begin
            mm_in_a_r <= 32'd0;
            mm_in_b_r <= 32'd0;
            state_r   <= S_WAIT_DONE;
          end else begin
            mm_in_a_r <= nxt_a_s;
            mm_in_b_r <= nxt_b_s;
            idx_r     <= idx_r + 32'd1;
          end
        end
        S_WAIT_DONE: begin
          if (mm_state == MM_ERROR) begin
            err_r       <= 1'b1;
            idx_r       <= 32'd0;
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end else if (mm_state == MM_IDLE) begin
            done_r      <= 1'b1;
            idx_r       <= 32'd0;
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end else begin
            state_r <= S_WAIT_DONE;
          end
        end
        S_ERR: begin
          cfg_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= S_IDLE;
        end
        default: begin
          cfg_ready_r <= 1'b1;
          s_ready_r   <= 1'b0;
          busy_r      <= 1'b0;
          idx_r       <= 32'd0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_r;
  assign s_ready   = s_ready_r;
  assign mm_start  = mm_start_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign mm_dims_a = mm_dims_a_r;
  assign mm_dims_b = mm_dims_b_r;
  assign mm_in_a   = mm_in_a_r;
  assign mm_in_b   = mm_in_b_r;

endmodule

// File: tb/tb_matmul_loader.sv
// Directed bench for matmul_loader: normal jobs, gapped stream, rejected descriptors,
// buffer-size boundary, reset mid-load and multiplier error. BUF_SIZE is reduced to 16.
module tb_matmul_loader;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [63:0] cfg_dims_a;
  logic [63:0] cfg_dims_b;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        mm_start;
  logic [63:0] mm_dims_a;
  logic [63:0] mm_dims_b;
  logic [31:0] mm_in_a;
  logic [31:0] mm_in_b;
  logic [31:0] mm_state;
  logic        busy;
  logic        done;
  logic        err;

  int passed = 0;
  int total  = 0;

  matmul_loader #(.BUF_SIZE(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_dims_a(cfg_dims_a), .cfg_dims_b(cfg_dims_b),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mm_start(mm_start), .mm_dims_a(mm_dims_a), .mm_dims_b(mm_dims_b),
    .mm_in_a(mm_in_a), .mm_in_b(mm_in_b), .mm_state(mm_state),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; outputs then show the new cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int ar, input int ac, input int br, input int bc,
                         input int off, input bit gap, input bit hold_cfg,
                         input bit mm_fail, input string tag);
    int na;
    int nb;
    int len;
    na  = ar * ac;
    nb  = br * bc;
    len = (na > nb) ? na : nb;
    chk({tag, "/cfg_ready_idle"}, 64'(cfg_ready), 64'd1);
    cfg_valid  = 1'b1;
    cfg_dims_a = {32'(ar), 32'(ac)};
    cfg_dims_b = {32'(br), 32'(bc)};
    tick();
    if (hold_cfg) begin
      cfg_dims_a = {32'd5, 32'd5};
      cfg_dims_b = {32'd5, 32'd5};
    end else begin
      cfg_valid = 1'b0;
    end
    chk({tag, "/s_ready_load"}, 64'(s_ready), 64'd1);
    chk({tag, "/busy_load"}, 64'(busy), 64'd1);
    chk({tag, "/dims_a"}, mm_dims_a, {32'(ar), 32'(ac)});
    for (int i = 0; i < na + nb; i++) begin
      if (i == na) cfg_valid = 1'b0;
      if (hold_cfg && i == 1) begin
        chk({tag, "/cfg_ready_busy"}, 64'(cfg_ready), 64'd0);
        chk({tag, "/dims_a_held"}, mm_dims_a, {32'(ar), 32'(ac)});
      end
      if (gap) begin
        s_valid = 1'b0;
        s_data  = 32'hdead_beef;
        tick();
      end
      s_valid = 1'b1;
      s_data  = 32'(off + i + 1);
      tick();
    end
    s_valid  = 1'b0;
    mm_state = 32'd1;
    chk({tag, "/mm_start"}, 64'(mm_start), 64'd1);
    chk({tag, "/s_ready_start"}, 64'(s_ready), 64'd0);
    for (int k = 0; k < len; k++) begin
      tick();
      chk($sformatf("%s/in_a[%0d]", tag, k), 64'(mm_in_a), (k < na) ? 64'(off + k + 1) : 64'd0);
      chk($sformatf("%s/in_b[%0d]", tag, k), 64'(mm_in_b), (k < nb) ? 64'(off + na + k + 1) : 64'd0);
      chk($sformatf("%s/start_low[%0d]", tag, k), 64'(mm_start), 64'd0);
    end
    tick();
    chk({tag, "/wait_in_a"}, 64'(mm_in_a), 64'd0);
    chk({tag, "/wait_busy"}, 64'(busy), 64'd1);
    chk({tag, "/dims_b_held"}, mm_dims_b, {32'(br), 32'(bc)});
    mm_state = 32'd2;
    tick();
    tick();
    chk({tag, "/no_early_done"}, 64'(done), 64'd0);
    mm_state = mm_fail ? 32'd4 : 32'd0;
    tick();
    mm_state = 32'd0;
    chk({tag, "/done"}, 64'(done), mm_fail ? 64'd0 : 64'd1);
    chk({tag, "/err"}, 64'(err), mm_fail ? 64'd1 : 64'd0);
    chk({tag, "/busy_end"}, 64'(busy), 64'd0);
    chk({tag, "/cfg_ready_end"}, 64'(cfg_ready), 64'd1);
    tick();
    chk({tag, "/done_pulse"}, 64'(done), 64'd0);
    chk({tag, "/err_pulse"}, 64'(err), 64'd0);
  endtask

  task automatic cfg_err(input int ar, input int ac, input int br, input int bc,
                         input string tag);
    chk({tag, "/cfg_ready_idle"}, 64'(cfg_ready), 64'd1);
    cfg_valid  = 1'b1;
    cfg_dims_a = {32'(ar), 32'(ac)};
    cfg_dims_b = {32'(br), 32'(bc)};
    tick();
    cfg_valid = 1'b0;
    chk({tag, "/err"}, 64'(err), 64'd1);
    chk({tag, "/s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "/mm_start"}, 64'(mm_start), 64'd0);
    tick();
    chk({tag, "/err_pulse"}, 64'(err), 64'd0);
    chk({tag, "/mm_start2"}, 64'(mm_start), 64'd0);
    chk({tag, "/cfg_ready_back"}, 64'(cfg_ready), 64'd1);
    chk({tag, "/busy_back"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_dims_a = 64'd0;
    cfg_dims_b = 64'd0;
    s_valid    = 1'b0;
    s_data     = 32'd0;
    mm_state   = 32'd0;
    tick();
    tick();
    chk("rst/cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst/busy", 64'(busy), 64'd0);
    chk("rst/s_ready", 64'(s_ready), 64'd0);
    chk("rst/mm_start", 64'(mm_start), 64'd0);
    chk("rst/dims_a", mm_dims_a, 64'd0);
    chk("rst/in_a", 64'(mm_in_a), 64'd0);
    rst = 1'b0;
    tick();

    run_job(2, 2, 2, 2, 0, 1'b0, 1'b0, 1'b0, "j2x2");
    run_job(2, 3, 3, 1, 0, 1'b0, 1'b0, 1'b0, "j2x3");
    run_job(2, 2, 2, 2, 0, 1'b1, 1'b0, 1'b0, "jgap");
    cfg_err(2, 3, 2, 2, "e_mismatch");
    cfg_err(0, 2, 2, 2, "e_zero");
    cfg_err(4, 4, 4, 4, "e_bufsize");
    run_job(3, 5, 5, 3, 40, 1'b0, 1'b0, 1'b0, "j_maxbuf");
    run_job(1, 2, 2, 1, 10, 1'b0, 1'b1, 1'b0, "jhold");

    // Reset after six of eight load beats
    cfg_valid  = 1'b1;
    cfg_dims_a = {32'd2, 32'd2};
    cfg_dims_b = {32'd2, 32'd2};
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data  = 32'(i + 1);
      tick();
    end
    s_valid = 1'b0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid/busy", 64'(busy), 64'd0);
    chk("rstmid/cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rstmid/mm_start", 64'(mm_start), 64'd0);
    chk("rstmid/dims_a", mm_dims_a, 64'd0);
    tick();
    chk("rstmid/no_start", 64'(mm_start), 64'd0);
    run_job(2, 2, 2, 2, 100, 1'b0, 1'b0, 1'b0, "jafter_rst");

    run_job(1, 1, 1, 1, 7, 1'b0, 1'b0, 1'b1, "jmm_err");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
